game_ctrl: RTL and testbench

Top-level game sequencer for the goose-run VGA game. It owns the game state (idle, running, crash, game over) and gates the scroll/animation logic through `run_en`. It latches pixel-level goose/bean collisions and commits them once per frame, and keeps the score, the high score and the difficulty level. It sits between the clock dividers / VGA sync and the draw_* sprite blocks; `score`, `score_hi`, `level` and `flash` feed the drawing logic directly.

---
 rtl/game_ctrl.sv | 158 +++++++++++++++
 tb/tb_game_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// goose-run game sequencer: idle/run/crash/over FSM, collision commit,
// score, high score, difficulty level and crash flash.
module game_ctrl #(
    parameter int SCORE_W      = 16,
    parameter int SCORE_DIV    = 10,
    parameter int LEVEL_STEP   = 100,
    parameter int MAX_LEVEL    = 7,
    parameter int FLASH_FRAMES = 50,
    parameter int FLASH_HALF   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               collide,
    output logic [1:0]         state,
    output logic               run_en,
    output logic               game_over,
    output logic               flash,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] score_hi,
    output logic [2:0]         level
);

    localparam int FW = $clog2(SCORE_DIV);
    localparam int LW = $clog2(LEVEL_STEP + 1);
    localparam int CW = $clog2(FLASH_FRAMES + 1);
    localparam int HW = $clog2(FLASH_HALF + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CRASH = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             cur, nxt;
    logic               btn_prev, start;
    logic               pend, pend_nx;
    logic [FW-1:0]      fcnt, fcnt_nx;
    logic [LW-1:0]      lcnt, lcnt_nx;
    logic [CW-1:0]      ccnt, ccnt_nx;
    logic [HW-1:0]      hcnt, hcnt_nx;
    logic               flash_nx;
    logic [SCORE_W-1:0] score_nx, hi_nx;
    logic [2:0]         level_nx;

    assign state = cur;
    assign start = btn_start & ~btn_prev;

    always_comb begin
        nxt      = cur;
        pend_nx  = pend;
        fcnt_nx  = fcnt;
        lcnt_nx  = lcnt;
        ccnt_nx  = ccnt;
        hcnt_nx  = hcnt;
        flash_nx = flash;
        score_nx = score;
        hi_nx    = score_hi;
        level_nx = level;
        unique case (cur)
            S_IDLE, S_OVER: begin
                if (start) begin
                    nxt      = S_RUN;
                    score_nx = '0;
                    level_nx = '0;
                    fcnt_nx  = '0;
                    lcnt_nx  = '0;
                    pend_nx  = 1'b0;
                end
            end
            S_RUN: begin
                // a collision seen mid-frame is only committed on the tick
                if (frame_tick && (pend || collide)) begin
                    nxt      = S_CRASH;
                    pend_nx  = 1'b0;
                    ccnt_nx  = '0;
                    hcnt_nx  = '0;
                    flash_nx = 1'b0;
                    if (score > score_hi)
                        hi_nx = score;
                end else begin
                    if (collide)
                        pend_nx = 1'b1;
                    if (frame_tick) begin
                        if (fcnt == FW'(SCORE_DIV - 1)) begin
                            fcnt_nx = '0;
                            if (score != '1)
                                score_nx = score + SCORE_W'(1);
                            if (lcnt == LW'(LEVEL_STEP - 1)) begin
                                lcnt_nx = '0;
                                if (level != 3'(MAX_LEVEL))
                                    level_nx = level + 3'd1;
                            end else begin
                                lcnt_nx = lcnt + LW'(1);
                            end
                        end else begin
                            fcnt_nx = fcnt + FW'(1);
                        end
                    end
                end
            end
            S_CRASH: begin
                if (frame_tick) begin
                    if (ccnt == CW'(FLASH_FRAMES - 1)) begin
                        nxt      = S_OVER;
                        flash_nx = 1'b0;
                        ccnt_nx  = '0;
                        hcnt_nx  = '0;
                    end else begin
                        ccnt_nx = ccnt + CW'(1);
                        if (hcnt == HW'(FLASH_HALF - 1)) begin
                            hcnt_nx  = '0;
                            flash_nx = ~flash;
                        end else begin
                            hcnt_nx = hcnt + HW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur       <= S_IDLE;
            btn_prev  <= 1'b1;
            pend      <= 1'b0;
            fcnt      <= '0;
            lcnt      <= '0;
            ccnt      <= '0;
            hcnt      <= '0;
            flash     <= 1'b0;
            score     <= '0;
            score_hi  <= '0;
            level     <= '0;
            run_en    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            cur       <= nxt;
            btn_prev  <= btn_start;
            pend      <= pend_nx;
            fcnt      <= fcnt_nx;
            lcnt      <= lcnt_nx;
            ccnt      <= ccnt_nx;
            hcnt      <= hcnt_nx;
            flash     <= flash_nx;
            score     <= score_nx;
            score_hi  <= hi_nx;
            level     <= level_nx;
            run_en    <= (nxt == S_RUN);
            game_over <= (nxt == S_OVER);
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a tick-count reference model pushes
// expected snapshots per cycle; each is popped and compared after the edge.
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        reset, frame_tick, btn_start, collide;
    logic [1:0]  state;
    logic        run_en, game_over, flash;
    logic [15:0] score, score_hi;
    logic [2:0]  level;

    game_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_start(btn_start), .collide(collide), .state(state),
        .run_en(run_en), .game_over(game_over), .flash(flash),
        .score(score), .score_hi(score_hi), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int fl;
        int sc;
        int hi;
        int lv;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model: score derived from total ticks in the game
    int m_state, gt, hi, ct;
    bit m_pend, m_btn;

    function automatic int sc_of(input int ticks);
        int s;
        s = ticks / 10;
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.st = m_state;
        e.sc = sc_of(gt);
        e.hi = hi;
        e.lv = (e.sc / 100 > 7) ? 7 : e.sc / 100;
        e.fl = (m_state == 2) ? (ct / 8) % 2 : 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        chk("state", 32'(state), e.st);
        chk("run_en", 32'(run_en), 32'(e.st == 1));
        chk("game_over", 32'(game_over), 32'(e.st == 3));
        chk("flash", 32'(flash), e.fl);
        chk("score", 32'(score), e.sc);
        chk("score_hi", 32'(score_hi), e.hi);
        chk("level", 32'(level), e.lv);
    endtask

    task automatic step(input bit t, input bit b, input bit c);
        bit se;
        @(negedge clk);
        reset = 1'b1; frame_tick = t; btn_start = b; collide = c;
        se = b && !m_btn;
        m_btn = b;
        case (m_state)
            0, 3: if (se) begin m_state = 1; gt = 0; m_pend = 0; end
            1: begin
                if (t && (m_pend || c)) begin
                    m_state = 2; ct = 0; m_pend = 0;
                    if (sc_of(gt) > hi) hi = sc_of(gt);
                end else begin
                    if (c) m_pend = 1;
                    if (t) gt++;
                end
            end
            default: if (t) begin ct++; if (ct == 50) m_state = 3; end
        endcase
        sb.push_back(snap());
        @(posedge clk); #1;
        compare();
    endtask

    task automatic rst(input bit b);
        @(negedge clk);
        reset = 1'b0; btn_start = b; frame_tick = 0; collide = 0;
        m_state = 0; gt = 0; hi = 0; ct = 0; m_pend = 0; m_btn = 1;
        sb.push_back(snap());
        @(posedge clk); #1;
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
    endtask

    task automatic press();
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
    endtask

    task automatic crash_seq();
        for (int i = 0; i < 50; i++) begin
            step(1, 0, 0);
            if (i < 49) step(0, 1, 0);
            step(0, 0, 0);
        end
    endtask

    initial begin
        reset = 1'b0; btn_start = 1'b1; frame_tick = 0; collide = 0;
        for (int i = 0; i < 3; i++) rst(1);
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        press();
        ticks(25);
        ticks(54);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        crash_seq();
        step(0, 0, 1);
        step(1, 0, 1);
        press();
        ticks(30);
        step(1, 0, 1);
        crash_seq();
        press();
        ticks(120);
        step(1, 0, 1);
        crash_seq();
        press();
        ticks(400);
        rst(0);
        step(1, 0, 0);
        press();
        ticks(10100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
